// File: rtl/surf_dna_pkg.sv
// Shared definitions for the DNA sequencer: DNA width, Wishbone register
// offsets (word index taken from wb_adr_i[3:2]), STAT bit positions and the
// readout state encoding.
package surf_dna_pkg;

    localparam int DNA_BITS = 96;

    // Word offsets within the 16-byte register window
    localparam logic [1:0] REG_STAT = 2'd0;  // 0x0
    localparam logic [1:0] REG_DNA0 = 2'd1;  // 0x4  DNA[31:0]
    localparam logic [1:0] REG_DNA1 = 2'd2;  // 0x8  DNA[63:32]
    localparam logic [1:0] REG_DNA2 = 2'd3;  // 0xC  DNA[95:64]

    // STAT register layout
    localparam int STAT_VALID_BIT = 0;
    localparam int STAT_BUSY_BIT  = 1;
    localparam int STAT_COUNT_LSB = 8;   // read-count occupies [15:8]
    localparam int STAT_START_BIT = 31;  // write 1 (with sel[3]) to start

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAP,
        SHIFT,
        GAP,
        DONE
    } dna_state_t;

endpackage

// File: rtl/surf_dna_sequencer.sv
// surf_dna_sequencer
// Runs the DNA_PORTE2 READ/SHIFT sequence autonomously (after reset when
// AUTO_START=1, or on a software start) and assembles the 96-bit device DNA.
// The completed value is published atomically on dna_o and through a
// four-word Wishbone register window.
//
// Ports:
//   wb_clk_i, wb_rst_n_i      clock (also the DNA port clock), async active-low reset
//   wb_cyc_i/stb_i/we_i       Wishbone classic slave handshake
//   wb_adr_i, wb_dat_i, wb_sel_i  byte address ([3:2] decoded), write data, byte selects
//   wb_dat_o, wb_ack_o        read data (combinational), registered ack pulse
//   wb_err_o, wb_rty_o        tied low
//   dna_read_o, dna_shift_o   DNA_PORTE2 READ / SHIFT
//   dna_dout_i                DNA_PORTE2 DOUT
//   dna_o, dna_valid_o        published DNA and its valid flag
//   busy_o                    a readout is in progress
module surf_dna_sequencer
    import surf_dna_pkg::*;
#(
    parameter int AUTO_START  = 1,
    parameter int SHIFT_GAP   = 0,
    parameter int WB_ADR_BITS = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [WB_ADR_BITS-1:0] wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic                   dna_read_o,
    output logic                   dna_shift_o,
    input  logic                   dna_dout_i,
    output logic [DNA_BITS-1:0]    dna_o,
    output logic                   dna_valid_o,
    output logic                   busy_o
);

    localparam logic [3:0] GAP_LAST = (SHIFT_GAP > 0) ? 4'(SHIFT_GAP - 1) : 4'd0;
    localparam logic [6:0] LAST_BIT = 7'(DNA_BITS - 1);

    dna_state_t          state_reg, state_next;
    logic [6:0]          bit_cnt_reg;
    logic [3:0]          gap_cnt_reg;
    logic [DNA_BITS-1:0] shift_reg;
    logic [DNA_BITS-1:0] dna_reg;
    logic                valid_reg;
    logic [7:0]          count_reg;
    logic                ack_reg;
    logic                auto_pending_reg;
    logic                start_req;
    logic                unused_bits;

    // Only the low address bits, sel[3] and dat[31] carry meaning here.
    assign unused_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

    // A start is sampled only in the ack cycle so each transaction fires once.
    assign start_req = ack_reg & wb_cyc_i & wb_stb_i & wb_we_i
                     & (wb_adr_i[3:2] == REG_STAT)
                     & wb_sel_i[3] & wb_dat_i[STAT_START_BIT];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start_req || auto_pending_reg) state_next = LOAD;
            LOAD:  state_next = CAP;
            CAP:   state_next = (bit_cnt_reg == LAST_BIT) ? DONE : SHIFT;
            SHIFT: state_next = (SHIFT_GAP == 0) ? CAP : GAP;
            GAP:   if (gap_cnt_reg == GAP_LAST) state_next = CAP;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port controls are decoded from the registered state, so they are
    // glitch-free and drop to zero the instant reset asserts.
    assign dna_read_o  = (state_reg == LOAD);
    assign dna_shift_o = (state_reg == SHIFT);
    assign busy_o      = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Datapath and Wishbone ack
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            bit_cnt_reg      <= '0;
            gap_cnt_reg      <= '0;
            shift_reg        <= '0;
            dna_reg          <= '0;
            valid_reg        <= 1'b0;
            count_reg        <= '0;
            ack_reg          <= 1'b0;
            auto_pending_reg <= (AUTO_START != 0);
        end else begin
            ack_reg <= wb_cyc_i & wb_stb_i & ~ack_reg;
            case (state_reg)
                IDLE: begin
                    // Pending auto-start is consumed by the IDLE->LOAD move.
                    auto_pending_reg <= 1'b0;
                    if (start_req) valid_reg <= 1'b0;
                end
                LOAD:  bit_cnt_reg <= '0;
                CAP: begin
                    // LSB-first assembly: the first DOUT bit ends in bit 0.
                    shift_reg   <= {dna_dout_i, shift_reg[DNA_BITS-1:1]};
                    bit_cnt_reg <= bit_cnt_reg + 7'd1;
                end
                SHIFT: gap_cnt_reg <= '0;
                GAP:   gap_cnt_reg <= gap_cnt_reg + 4'd1;
                DONE: begin
                    dna_reg   <= shift_reg;
                    valid_reg <= 1'b1;
                    if (count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    always_comb begin
        wb_dat_o = '0;
        case (wb_adr_i[3:2])
            REG_STAT: begin
                wb_dat_o[STAT_VALID_BIT]          = valid_reg;
                wb_dat_o[STAT_BUSY_BIT]           = busy_o;
                wb_dat_o[STAT_COUNT_LSB +: 8]     = count_reg;
            end
            REG_DNA0: wb_dat_o = dna_reg[31:0];
            REG_DNA1: wb_dat_o = dna_reg[63:32];
            REG_DNA2: wb_dat_o = dna_reg[95:64];
            default:  wb_dat_o = '0;
        endcase
    end

    assign wb_ack_o    = ack_reg;
    assign wb_err_o    = 1'b0;
    assign wb_rty_o    = 1'b0;
    assign dna_o       = dna_reg;
    assign dna_valid_o = valid_reg;

endmodule

// File: tb/tb_surf_dna_sequencer.sv
// Directed bench for surf_dna_sequencer. Two instances share the clock and
// Wishbone data/address lines: dut_a (AUTO_START=1, SHIFT_GAP=0) and
// dut_b (AUTO_START=0, SHIFT_GAP=3), each with its own reset, cyc line and
// behavioural DNA_PORTE2 model.
module tb_surf_dna_sequencer;

    logic        clk;
    logic        rst_n [2];
    logic        cyc   [2];
    logic        stb, we;
    logic [3:0]  adr, sel;
    logic [31:0] wdat;
    logic [31:0] rdat  [2];
    logic        ack   [2];
    logic        err   [2];
    logic        rty   [2];
    logic        rd    [2];
    logic        sh    [2];
    logic        dout  [2];
    logic        valid [2];
    logic        busy  [2];
    logic [95:0] dna   [2];
    logic [95:0] model_val [2];

    int tests_run;
    int tests_failed;

    // Results of the most recent monitor_seq call
    int m_reads, m_shifts, m_busy, m_first, m_min, m_max;
    bit m_held;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    surf_dna_sequencer #(.AUTO_START(1), .SHIFT_GAP(0), .WB_ADR_BITS(4)) dut_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n[0]),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
        .wb_err_o(err[0]), .wb_rty_o(rty[0]),
        .dna_read_o(rd[0]), .dna_shift_o(sh[0]), .dna_dout_i(dout[0]),
        .dna_o(dna[0]), .dna_valid_o(valid[0]), .busy_o(busy[0])
    );

    surf_dna_sequencer #(.AUTO_START(0), .SHIFT_GAP(3), .WB_ADR_BITS(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n[1]),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
        .wb_err_o(err[1]), .wb_rty_o(rty[1]),
        .dna_read_o(rd[1]), .dna_shift_o(sh[1]), .dna_dout_i(dout[1]),
        .dna_o(dna[1]), .dna_valid_o(valid[1]), .busy_o(busy[1])
    );

    // DNA_PORTE2 behaviour: READ loads the value, SHIFT moves it right,
    // DOUT presents bit 0.
    for (genvar gi = 0; gi < 2; gi++) begin : g_model
        logic [95:0] sr;
        always @(posedge clk) begin
            if (rd[gi])      sr <= model_val[gi];
            else if (sh[gi]) sr <= {1'b0, sr[95:1]};
        end
        assign dout[gi] = sr[0];
    end

    // One Wishbone classic transaction; ack is expected one cycle after strobe.
    task automatic wb_xfer(input int idx, input bit w, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r);
        @(negedge clk);
        cyc[idx] = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        tests_run++;
        if (ack[idx] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wb_ack dut=%0d adr=%h: got %b expected 1", idx, a, ack[idx]);
        end
        r = rdat[idx];
        @(posedge clk); #1;
        cyc[idx] = 1'b0; stb = 1'b0; we = 1'b0;
        $display("[TB] wb dut=%0d %s adr=0x%h wdat=0x%h sel=%b rdat=0x%h",
                 idx, w ? "WR" : "RD", a, d, s, r);
    endtask

    // Samples one DUT on falling edges while busy (bounded by budget).
    task automatic monitor_seq(input int idx, input int budget, input logic [95:0] hold_val);
        int last_sh;
        last_sh = -1;
        m_reads = 0; m_shifts = 0; m_busy = 0; m_first = -1;
        m_min = 1000000; m_max = -1; m_held = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (!busy[idx]) break;
            m_busy++;
            if (rd[idx]) begin
                m_reads++;
                if (m_first < 0) m_first = c;
            end
            if (sh[idx]) begin
                m_shifts++;
                if (last_sh >= 0) begin
                    if (c - last_sh < m_min) m_min = c - last_sh;
                    if (c - last_sh > m_max) m_max = c - last_sh;
                end
                last_sh = c;
            end
            if (dna[idx] !== hold_val) m_held = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({ack[i], rd[i], sh[i], valid[i], busy[i], err[i], rty[i]} !== 7'b0) begin
                tests_failed++;
                $display("FAIL reset_ctrl dut=%0d: got %b expected 0000000", i,
                         {ack[i], rd[i], sh[i], valid[i], busy[i], err[i], rty[i]});
            end
            tests_run++;
            if (dna[i] !== 96'd0) begin
                tests_failed++;
                $display("FAIL reset_dna dut=%0d: got %h expected 0", i, dna[i]);
            end
        end
    endtask

    task automatic test_auto_start;
        logic [31:0] r;
        @(negedge clk);
        rst_n[0] = 1'b1;
        monitor_seq(0, 400, 96'd0);
        tests_run++; if (m_first !== 1) begin tests_failed++; $display("FAIL auto_first_read: got %0d expected 1", m_first); end
        tests_run++; if (m_reads !== 1) begin tests_failed++; $display("FAIL auto_read_count: got %0d expected 1", m_reads); end
        tests_run++; if (m_shifts !== 95) begin tests_failed++; $display("FAIL auto_shifts: got %0d expected 95", m_shifts); end
        // 192-cycle readout plus the DONE cycle
        tests_run++; if (m_busy !== 193) begin tests_failed++; $display("FAIL auto_busy_cycles: got %0d expected 193", m_busy); end
        tests_run++; if (m_min !== 2 || m_max !== 2) begin tests_failed++; $display("FAIL auto_shift_spacing: got %0d..%0d expected 2..2", m_min, m_max); end
        tests_run++; if (m_held !== 1'b1) begin tests_failed++; $display("FAIL auto_no_partial: dna_o changed before DONE, expected 0 throughout"); end
        tests_run++; if (valid[0] !== 1'b1) begin tests_failed++; $display("FAIL auto_valid: got %b expected 1", valid[0]); end
        tests_run++; if (dna[0] !== 96'hA5A50000_12345678_9ABCDEF0) begin tests_failed++; $display("FAIL auto_dna: got %h expected a5a5000012345678_9abcdef0", dna[0]); end
        wb_xfer(0, 1'b0, 4'h4, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h9ABCDEF0) begin tests_failed++; $display("FAIL auto_reg_dna0: got %h expected 9abcdef0", r); end
        wb_xfer(0, 1'b0, 4'h8, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h12345678) begin tests_failed++; $display("FAIL auto_reg_dna1: got %h expected 12345678", r); end
        wb_xfer(0, 1'b0, 4'hC, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'hA5A50000) begin tests_failed++; $display("FAIL auto_reg_dna2: got %h expected a5a50000", r); end
        wb_xfer(0, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h00000101) begin tests_failed++; $display("FAIL auto_reg_stat: got %h expected 00000101", r); end
    endtask

    task automatic test_manual_start;
        logic [31:0] r;
        int seen;
        seen = 0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rd[1] || busy[1]) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL manual_no_autostart: got %0d active cycles expected 0", seen); end
        wb_xfer(1, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h0) begin tests_failed++; $display("FAIL manual_stat_idle: got %h expected 00000000", r); end
        // Start bit without sel[3] is not a start
        wb_xfer(1, 1'b1, 4'h0, 32'h80000000, 4'b0111, r);
        tests_run++; if (busy[1] !== 1'b0) begin tests_failed++; $display("FAIL manual_sel_gate: got busy %b expected 0", busy[1]); end
        // sel[3] without bit 31 is not a start
        wb_xfer(1, 1'b1, 4'h0, 32'h7FFFFFFF, 4'b1000, r);
        tests_run++; if (busy[1] !== 1'b0) begin tests_failed++; $display("FAIL manual_bit31_gate: got busy %b expected 0", busy[1]); end
        wb_xfer(1, 1'b1, 4'h0, 32'h80000000, 4'b1000, r);
        tests_run++; if (busy[1] !== 1'b1) begin tests_failed++; $display("FAIL manual_busy_rise: got %b expected 1", busy[1]); end
        monitor_seq(1, 1000, 96'd0);
        tests_run++; if (m_first !== 1 || m_reads !== 1) begin tests_failed++; $display("FAIL manual_read_pulse: got first %0d count %0d expected 1/1", m_first, m_reads); end
        tests_run++; if (m_shifts !== 95) begin tests_failed++; $display("FAIL manual_shifts: got %0d expected 95", m_shifts); end
        tests_run++; if (m_min !== 5 || m_max !== 5) begin tests_failed++; $display("FAIL manual_gap_spacing: got %0d..%0d expected 5..5", m_min, m_max); end
        // 192 + 95*3 = 477 readout cycles plus DONE
        tests_run++; if (m_busy !== 478) begin tests_failed++; $display("FAIL manual_busy_cycles: got %0d expected 478", m_busy); end
        tests_run++; if (dna[1] !== 96'h01234567_89ABCDEF_FEDCBA98) begin tests_failed++; $display("FAIL manual_dna: got %h expected 0123456789abcdeffedcba98", dna[1]); end
        wb_xfer(1, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h00000101) begin tests_failed++; $display("FAIL manual_stat_done: got %h expected 00000101", r); end
    endtask

    task automatic test_register_writes;
        logic [31:0] r;
        wb_xfer(1, 1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, r);
        wb_xfer(1, 1'b1, 4'hC, 32'h80000000, 4'b1000, r);
        tests_run++; if (busy[1] !== 1'b0) begin tests_failed++; $display("FAIL regwr_no_start: got busy %b expected 0", busy[1]); end
        wb_xfer(1, 1'b0, 4'h4, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'hFEDCBA98) begin tests_failed++; $display("FAIL regwr_dna0_ro: got %h expected fedcba98", r); end
        wb_xfer(1, 1'b0, 4'hC, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h01234567) begin tests_failed++; $display("FAIL regwr_dna2_ro: got %h expected 01234567", r); end
    endtask

    task automatic test_start_while_busy;
        logic [31:0] r;
        wb_xfer(1, 1'b1, 4'h0, 32'h80000000, 4'b1000, r);
        repeat (20) @(negedge clk);
        wb_xfer(1, 1'b1, 4'h0, 32'h80000000, 4'b1000, r);
        monitor_seq(1, 1000, 96'h01234567_89ABCDEF_FEDCBA98);
        tests_run++; if (m_reads !== 0) begin tests_failed++; $display("FAIL busy_no_second_read: got %0d expected 0", m_reads); end
        tests_run++; if (valid[1] !== 1'b1) begin tests_failed++; $display("FAIL busy_completes: got valid %b expected 1", valid[1]); end
        wb_xfer(1, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h00000201) begin tests_failed++; $display("FAIL busy_count_once: got %h expected 00000201", r); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        int n, c;
        n = 0; c = 0;
        wb_xfer(0, 1'b1, 4'h0, 32'h80000000, 4'b1000, r);
        while (n < 50 && c < 400) begin
            @(negedge clk);
            c++;
            if (sh[0]) n++;
        end
        tests_run++; if (n !== 50) begin tests_failed++; $display("FAIL rstmid_reach: got %0d shifts expected 50", n); end
        @(negedge clk);  // now in the capture of bit 50
        #1 rst_n[0] = 1'b0;
        #1;
        tests_run++;
        if ({ack[0], rd[0], sh[0], valid[0], busy[0]} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async_ctrl: got %b expected 00000", {ack[0], rd[0], sh[0], valid[0], busy[0]});
        end
        tests_run++; if (dna[0] !== 96'd0) begin tests_failed++; $display("FAIL rstmid_async_dna: got %h expected 0", dna[0]); end
        @(negedge clk);
        rst_n[0] = 1'b1;
        monitor_seq(0, 400, 96'd0);
        tests_run++; if (m_first !== 1 || m_reads !== 1 || m_busy !== 193) begin tests_failed++; $display("FAIL rstmid_restart: got first %0d reads %0d busy %0d expected 1/1/193", m_first, m_reads, m_busy); end
        tests_run++; if (dna[0] !== 96'hA5A50000_12345678_9ABCDEF0) begin tests_failed++; $display("FAIL rstmid_dna: got %h expected a5a50000123456789abcdef0", dna[0]); end
        wb_xfer(0, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h00000101) begin tests_failed++; $display("FAIL rstmid_stat: got %h expected 00000101", r); end
    endtask

    task automatic test_restart_update;
        logic [31:0] r;
        model_val[0] = 96'hDEADBEEF_CAFEF00D_13579BDF;
        wb_xfer(0, 1'b1, 4'h0, 32'h80000000, 4'b1000, r);
        tests_run++; if (valid[0] !== 1'b0) begin tests_failed++; $display("FAIL restart_valid_drop: got %b expected 0", valid[0]); end
        tests_run++; if (dna[0] !== 96'hA5A50000_12345678_9ABCDEF0) begin tests_failed++; $display("FAIL restart_dna_hold: got %h expected a5a50000123456789abcdef0", dna[0]); end
        monitor_seq(0, 400, 96'hA5A50000_12345678_9ABCDEF0);
        tests_run++; if (m_held !== 1'b1 || m_busy !== 193) begin tests_failed++; $display("FAIL restart_atomic: got held %b busy %0d expected 1/193", m_held, m_busy); end
        tests_run++; if (dna[0] !== 96'hDEADBEEF_CAFEF00D_13579BDF) begin tests_failed++; $display("FAIL restart_dna_new: got %h expected deadbeefcafef00d13579bdf", dna[0]); end
        tests_run++; if (valid[0] !== 1'b1) begin tests_failed++; $display("FAIL restart_valid: got %b expected 1", valid[0]); end
        wb_xfer(0, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h00000201) begin tests_failed++; $display("FAIL restart_stat: got %h expected 00000201", r); end
    endtask

    task automatic test_saturation;
        logic [31:0] r;
        int c;
        bit timeout;
        timeout = 1'b0;
        // Count is 2 here; 256 more readouts would wrap to 2 without saturation.
        for (int k = 0; k < 256; k++) begin
            wb_xfer(0, 1'b1, 4'h0, 32'h80000000, 4'b1000, r);
            c = 0;
            while (busy[0] && c < 300) begin
                @(negedge clk);
                c++;
            end
            if (busy[0]) begin
                timeout = 1'b1;
                break;
            end
        end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL sat_timeout: got timeout %b expected 0", timeout); end
        wb_xfer(0, 1'b0, 4'h0, 32'h0, 4'hF, r);
        tests_run++; if (r !== 32'h0000FF01) begin tests_failed++; $display("FAIL sat_count: got %h expected 0000ff01", r); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        cyc[0] = 1'b0; cyc[1] = 1'b0;
        stb = 1'b0; we = 1'b0; adr = 4'h0; sel = 4'h0; wdat = 32'h0;
        model_val[0] = 96'hA5A50000_12345678_9ABCDEF0;
        model_val[1] = 96'h01234567_89ABCDEF_FEDCBA98;
        test_reset();
        test_auto_start();
        test_manual_start();
        test_register_writes();
        test_start_while_busy();
        test_reset_mid();
        test_restart_update();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
